operm_pipe: RTL and testbench

Pipelined, back-pressured output permutator for the piston datapath: the parametrised successor of the combinational `operm_dat` butterfly. Each beat carries `SLICES` data lanes plus a permutation/control word. The block reorders lanes in one of four modes (arbitrary gather, rotate, broadcast, bypass) and forwards the control selector alongside the data. It sits between the slice compute array and the output stream and adds valid/ready flow control with a configurable pipeline depth.

---
 rtl/operm_pipe.sv | 125 ++++++++++++
 tb/tb_operm_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operm_pipe.sv
// operm_pipe: elastic, pipelined lane permutator.
// Modes reduce to per-lane addresses, resolved one address bit per mux level.
module operm_pipe #(
  parameter int SLICES     = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int STAGES     = 2,
  localparam int AW  = $clog2(SLICES),
  localparam int KPW = SEL_WIDTH + 2 + SLICES * AW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SLICES*DATA_WIDTH-1:0] t_dat_dat,
  input  logic [KPW-1:0]               t_kp_dat,
  input  logic                         t_valid,
  output logic                         t_ready,
  output logic [SLICES*DATA_WIDTH-1:0] i_dat_dat,
  output logic [SEL_WIDTH-1:0]         k_ctrl,
  output logic                         i_valid,
  input  logic                         i_ready
);

  localparam int DW = DATA_WIDTH;

  logic [1:0]                          w_mode;
  logic [SEL_WIDTH-1:0]                w_sel;
  logic [SLICES-1:0][AW-1:0]           w_ea;
  logic [SLICES-1:0][SLICES-1:0][DW-1:0] w_src;
  logic                                w_unused;

  assign w_mode = t_kp_dat[SLICES*AW +: 2];
  assign w_sel  = t_kp_dat[KPW-1 -: SEL_WIDTH];

  always_comb begin
    w_ea = '0;
    for (int k = 0; k < SLICES; k++) begin
      unique case (w_mode)
        2'd0:    w_ea[k] = t_kp_dat[AW*k +: AW];
        2'd1:    w_ea[k] = AW'(k) + t_kp_dat[AW-1:0];
        2'd2:    w_ea[k] = t_kp_dat[AW-1:0];
        default: w_ea[k] = AW'(k);
      endcase
    end
  end

  // Every output lane starts with the full set of input lanes as candidates
  for (genvar k = 0; k < SLICES; k++) begin : g_src
    assign w_src[k] = t_dat_dat;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int B  = (s * AW) / STAGES;
    localparam int E  = ((s + 1) * AW) / STAGES;
    localparam int NI = SLICES >> B;
    localparam int NO = SLICES >> E;

    logic [SLICES-1:0][NI-1:0][DW-1:0] w_in;
    logic [SLICES-1:0][NO-1:0][DW-1:0] w_nxt;
    logic [NI-1:0][DW-1:0]             w_c;
    logic [SLICES-1:0][AW-1:0]         w_ain;
    logic [SEL_WIDTH-1:0]              w_sin;
    logic                              w_vin;
    logic                              w_go;
    logic [SLICES-1:0][NO-1:0][DW-1:0] r_dat;
    logic [SLICES-1:0][AW-1:0]         r_adr;
    logic [SEL_WIDTH-1:0]              r_sel;
    logic                              r_vld;

    if (s == 0) begin : g_head
      assign w_in  = w_src;
      assign w_ain = w_ea;
      assign w_sin = w_sel;
      assign w_vin = t_valid;
    end else begin : g_body
      assign w_in  = g_st[s-1].r_dat;
      assign w_ain = g_st[s-1].r_adr;
      assign w_sin = g_st[s-1].r_sel;
      assign w_vin = g_st[s-1].r_vld;
    end

    if (s == STAGES - 1) begin : g_tail
      assign w_go = !r_vld || i_ready;
    end else begin : g_mid
      assign w_go = !r_vld || g_st[s+1].w_go;
    end

    // Level l halves the candidate list using address bit B+l
    always_comb begin
      w_nxt = '0;
      w_c   = '0;
      for (int k = 0; k < SLICES; k++) begin
        w_c = w_in[k];
        for (int l = 0; l < E - B; l++) begin
          for (int m = 0; m < (NI >> (l + 1)); m++) begin
            w_c[m] = w_ain[k][B+l] ? w_c[2*m+1] : w_c[2*m];
          end
        end
        w_nxt[k] = w_c[NO-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_dat <= '0;
        r_adr <= '0;
        r_sel <= '0;
      end else if (w_go) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_dat <= w_nxt;
          r_adr <= w_ain;
          r_sel <= w_sin;
        end
      end
    end
  end

  assign t_ready   = g_st[0].w_go;
  assign i_valid   = g_st[STAGES-1].r_vld;
  assign k_ctrl    = g_st[STAGES-1].r_sel;
  assign i_dat_dat = g_st[STAGES-1].r_dat;
  assign w_unused  = ^g_st[STAGES-1].r_adr;

endmodule

// File: tb/tb_operm_pipe.sv
// tb_operm_pipe: random and directed stimulus against a lane-level model
// of the permutation rules, with a per-cycle output compare process.
module tb_operm_pipe;

  localparam int NS  = 4;
  localparam int DW  = 8;
  localparam int SW  = 4;
  localparam int ST  = 2;
  localparam int AW  = 2;
  localparam int KPW = SW + 2 + NS * AW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NS*DW-1:0] t_dat = '0;
  logic [KPW-1:0] t_kp = '0;
  logic           t_valid = 1'b0;
  logic           t_ready;
  logic [NS*DW-1:0] i_dat;
  logic [SW-1:0]  k_ctrl;
  logic           i_valid;
  logic           i_ready = 1'b0;

  operm_pipe #(
    .SLICES(NS), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .STAGES(ST)
  ) dut (
    .clk(clk), .reset(reset),
    .t_dat_dat(t_dat), .t_kp_dat(t_kp),
    .t_valid(t_valid), .t_ready(t_ready),
    .i_dat_dat(i_dat), .k_ctrl(k_ctrl),
    .i_valid(i_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS*DW-1:0] d;
    logic [SW-1:0]    s;
    int               c;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    n_emit = 0;
  beat_t q[$];
  bit    prev_stall = 1'b0;
  logic [NS*DW-1:0] prev_d;
  logic [SW-1:0]    prev_s;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: output lane k takes input lane src(k) from the mode rules
  function automatic logic [NS*DW-1:0] perm(logic [NS*DW-1:0] d,
                                            logic [KPW-1:0] kp);
    int a[NS];
    int mode;
    int src;
    logic [NS*DW-1:0] r;
    r = '0;
    for (int k = 0; k < NS; k++) a[k] = int'(kp[AW*k +: AW]);
    mode = int'(kp[NS*AW +: 2]);
    for (int k = 0; k < NS; k++) begin
      case (mode)
        0:       src = a[k];
        1:       src = (k + a[0]) % NS;
        2:       src = a[0];
        default: src = k;
      endcase
      r[DW*k +: DW] = d[DW*src +: DW];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {31'd0, i_valid, k_ctrl, i_dat},
            {31'd0, 1'b1, prev_s, prev_d});
      if (i_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(q.size()), 64'd1);
        end else begin
          b = q.pop_front();
          chk("out_data", 64'(i_dat), 64'(b.d));
          chk("out_sel", 64'(k_ctrl), 64'(b.s));
          chk("not_early", 64'(cyc - b.c >= ST), 64'd1);
          n_emit++;
        end
      end
      prev_stall = i_valid && !i_ready;
      prev_d = i_dat;
      prev_s = k_ctrl;
      if (t_valid && t_ready) begin
        b.d = perm(t_dat, t_kp);
        b.s = t_kp[KPW-1 -: SW];
        b.c = cyc;
        q.push_back(b);
      end
    end
  end

  task automatic directed(string nm, logic [31:0] d, logic [KPW-1:0] kp,
                          logic [31:0] exp, logic [SW-1:0] es);
    int lat;
    @(posedge clk); #1;
    i_ready = 1'b1;
    t_dat = d;
    t_kp = kp;
    t_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_tready"}, 64'(t_ready), 64'd1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!i_valid && lat < 10);
    chk({nm, "_latency"}, 64'(lat), 64'(ST));
    chk({nm, "_dat"}, 64'(i_dat), 64'(exp));
    chk({nm, "_sel"}, 64'(k_ctrl), 64'(es));
    @(posedge clk); #1;
  endtask

  task automatic drain(string nm);
    int n = 0;
    i_ready = 1'b1;
    t_valid = 1'b0;
    while ((q.size() != 0 || i_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int nacc;
    int e0;
    int lows;
    int run;
    int g;
    int acc_cnt;
    bit acc;
    bit stop;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(i_valid), 64'd0);
    chk("rst_dat", 64'(i_dat), 64'd0);
    chk("rst_ctrl", 64'(k_ctrl), 64'd0);
    chk("rst_tready_noready", 64'(t_ready), 64'd1);

    directed("bypass", 32'h33221100, {4'h5, 2'd3, 8'h00}, 32'h33221100, 4'h5);
    directed("gather", 32'h33221100, {4'hA, 2'd0, 8'h0D}, 32'h00003311, 4'hA);
    directed("rotate", 32'h33221100, {4'h3, 2'd1, 8'h03}, 32'h22110033, 4'h3);
    directed("bcast", 32'h33221100, {4'hC, 2'd2, 8'h02}, 32'h22222222, 4'hC);

    // Fill with the output blocked: exactly ST beats fit
    i_ready = 1'b0;
    t_valid = 1'b1;
    nacc = 0;
    stop = 1'b0;
    for (int i = 0; i < 6 && !stop; i++) begin
      t_dat = $urandom;
      t_kp = KPW'($urandom);
      @(negedge clk);
      if (t_ready) begin
        nacc++;
        @(posedge clk); #1;
      end else begin
        stop = 1'b1;
      end
    end
    chk("stall_accepts", 64'(nacc), 64'(ST));
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 drain("stall_drain");

    // Ten incrementing beats under random backpressure
    e0 = n_emit;
    g = 0;
    for (int i = 0; i < 10 && g < 1000; g++) begin
      t_valid = 1'b1;
      t_dat = 32'h01010101 * 32'(i + 1);
      t_kp = KPW'($urandom);
      i_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (t_ready) i++;
      @(posedge clk); #1;
    end
    drain("bp_drain");
    chk("bp_count", 64'(n_emit - e0), 64'd10);

    // 64 back-to-back beats
    e0 = n_emit;
    lows = 0;
    run = 0;
    i_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          t_valid = 1'b1;
          t_dat = $urandom;
          t_kp = KPW'($urandom);
          @(negedge clk);
          if (!t_ready) lows++;
          @(posedge clk); #1;
        end
        t_valid = 1'b0;
      end
      begin
        int w = 0;
        while (!i_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        while (i_valid && run < 100) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk("tput_run", 64'(run), 64'd64);
    chk("tput_tready_low", 64'(lows), 64'd0);
    drain("tput_drain");
    chk("tput_count", 64'(n_emit - e0), 64'd64);

    // Random traffic on both sides
    e0 = n_emit;
    acc_cnt = 0;
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!t_valid || acc) begin
        t_dat = $urandom;
        t_kp = KPW'($urandom);
      end
      t_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = t_valid && t_ready;
      if (acc) acc_cnt++;
      @(posedge clk); #1;
    end
    drain("rand_drain");
    chk("rand_count", 64'(n_emit - e0), 64'(acc_cnt));

    // Reset with two beats in flight
    i_ready = 1'b0;
    t_valid = 1'b1;
    t_dat = 32'hAABBCCDD;
    t_kp = KPW'($urandom);
    @(negedge clk);
    chk("mid_acc0", 64'(t_ready), 64'd1);
    @(posedge clk); #1;
    t_dat = 32'h11223344;
    @(negedge clk);
    chk("mid_acc1", 64'(t_ready), 64'd1);
    @(posedge clk); #1;
    e0 = n_emit;
    reset = 1'b1;
    i_ready = 1'b1;
    t_dat = 32'h55667788;
    @(posedge clk); #1;
    reset = 1'b0;
    t_valid = 1'b0;
    @(negedge clk);
    chk("mid_valid", 64'(i_valid), 64'd0);
    chk("mid_dat", 64'(i_dat), 64'd0);
    chk("mid_ctrl", 64'(k_ctrl), 64'd0);
    chk("mid_tready", 64'(t_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("mid_no_ghost", 64'(i_valid), 64'd0);
    chk("mid_emits", 64'(n_emit - e0), 64'd0);
    directed("post_rst", 32'h0F1E2D3C, {4'h9, 2'd1, 8'h01}, 32'h3C0F1E2D, 4'h9);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end

endmodule
